// File: rtl/fmap_buf_pkg.sv
// Shared types and sizes for the feature-map RAM burst controller.
package fmap_buf_pkg;

    localparam int unsigned FMAP_DEPTH   = 128;
    localparam int unsigned FMAP_AW      = 7;
    localparam int unsigned FMAP_DW      = 64;
    localparam int unsigned FMAP_STALL_W = 16;

    // Burst controller states; encoding is fixed for debug visibility.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR    = 2'd1,
        ST_RD    = 2'd2,
        ST_DRAIN = 2'd3
    } fmap_state_e;

endpackage

// File: rtl/fmap_skid2.sv
// Two-entry registered FIFO that absorbs the one-cycle RAM read latency.
// The head entry drives the read stream directly from flops.
module fmap_skid2
    import fmap_buf_pkg::*;
#(
    parameter int unsigned DW = FMAP_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    occ,
    output logic [DW-1:0] head_data,
    output logic          head_valid
);

    logic [DW-1:0] ent0_q;
    logic [DW-1:0] ent1_q;
    logic [1:0]    occ_q;
    logic          do_pop;

    // A pop on an empty buffer is meaningless and is ignored.
    assign do_pop = pop && (occ_q != 2'd0);

    // Entry storage and occupancy; ent0 is always the head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q  <= 2'd0;
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        ent0_q <= push_data;
                        occ_q  <= 2'd1;
                    end else if (occ_q == 2'd1) begin
                        ent1_q <= push_data;
                        occ_q  <= 2'd2;
                    end
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd2) begin
                        ent0_q <= ent1_q;
                        ent1_q <= push_data;
                    end else begin
                        ent0_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // The issue throttle upstream must never let a push hit a full buffer.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !do_pop && (occ_q == 2'd2)));

    assign occ        = occ_q;
    assign head_data  = ent0_q;
    assign head_valid = (occ_q != 2'd0);

endmodule

// File: rtl/fmap_buf_ctrl.sv
// Burst access controller for one 128x64 single-port feature-map RAM.
// Write bursts pass the input stream straight to the RAM; read bursts stream
// RAM words out through a two-entry skid buffer.
// Optional build macro FMAP_BUF_STALL_CNT_EN enables the backpressure counter.
module fmap_buf_ctrl
    import fmap_buf_pkg::*;
#(
    parameter int unsigned DW = FMAP_DW,
    parameter int unsigned AW = FMAP_AW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_rd,
    input  logic [AW-1:0]           cmd_base,
    input  logic [AW-1:0]           cmd_len_m1,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DW-1:0]           out_data,
    output logic                    mem_we,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    input  logic [DW-1:0]           mem_rdata,
    output logic                    busy,
    output logic                    done,
    output logic [FMAP_STALL_W-1:0] stall_cnt
);

    fmap_state_e   state_q;
    fmap_state_e   state_d;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;
    logic [AW-1:0] rem_q;
    logic [AW-1:0] rem_d;
    logic          inflight_q;
    logic          inflight_d;
    logic          done_q;
    logic          done_d;
    logic [1:0]    occ;
    logic          pop;
    logic [2:0]    rd_load;

    assign pop     = out_valid && out_ready;
    // Words held or on their way into the skid buffer.
    assign rd_load = 3'(occ) + 3'(inflight_q);

    // Skid buffer fed by the read issued in the previous cycle.
    fmap_skid2 #(
        .DW (DW)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight_q),
        .push_data  (mem_rdata),
        .pop        (pop),
        .occ        (occ),
        .head_data  (out_data),
        .head_valid (out_valid)
    );

    // Controller state and burst counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    // Next-state, counter updates and RAM/stream handshakes.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        inflight_d = 1'b0;
        done_d     = 1'b0;
        cmd_ready  = 1'b0;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_base;
                    rem_d   = cmd_len_m1;
                    state_d = cmd_rd ? ST_RD : ST_WR;
                end
            end
            ST_WR: begin
                // Zero-latency pass-through: the beat is written on this edge.
                in_ready  = 1'b1;
                mem_we    = in_valid;
                mem_addr  = addr_q;
                mem_wdata = in_data;
                if (in_valid) begin
                    addr_d = addr_q + AW'(1);
                    rem_d  = rem_q - AW'(1);
                    if (rem_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RD: begin
                // Issue only if the word is guaranteed a skid slot next cycle;
                // counting this cycle's pop keeps 1 word/cycle flowing.
                mem_addr = addr_q;
                if (rd_load < (3'd2 + 3'(pop))) begin
                    inflight_d = 1'b1;
                    addr_d     = addr_q + AW'(1);
                    rem_d      = rem_q - AW'(1);
                    if (rem_q == '0) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && (occ == 2'd1) && !inflight_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

`ifdef FMAP_BUF_STALL_CNT_EN
    logic [FMAP_STALL_W-1:0] stall_q;
    logic                    stall_ev;

    assign stall_ev = ((state_q == ST_WR) && !in_valid) || (out_valid && !out_ready);

    // Saturating stall counter, restarted by every accepted command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (cmd_valid && cmd_ready) begin
            stall_q <= '0;
        end else if (stall_ev && (stall_q != {FMAP_STALL_W{1'b1}})) begin
            stall_q <= stall_q + FMAP_STALL_W'(1);
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fmap_buf_ctrl.sv
// Self-checking bench for fmap_buf_ctrl with a behavioural RAM and a
// word-array reference of what the RAM should hold.
module tb_fmap_buf_ctrl;
    import fmap_buf_pkg::*;

    localparam int unsigned DW    = FMAP_DW;
    localparam int unsigned AW    = FMAP_AW;
    localparam int unsigned DEPTH = FMAP_DEPTH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_rd;
    logic [AW-1:0] cmd_base;
    logic [AW-1:0] cmd_len_m1;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          done;
    logic [15:0]   stall_cnt;

    int nvec = 0;
    int nerr = 0;

    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] exp_mem [DEPTH];

    fmap_buf_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rd     (cmd_rd),
        .cmd_base   (cmd_base),
        .cmd_len_m1 (cmd_len_m1),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    // Single-port RAM, one-cycle synchronous read.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Write burst; data either 0xA0+beat or random, optional input gaps.
    task automatic do_write(input logic [AW-1:0] base, input logic [AW-1:0] len_m1,
                            input bit gaps, input bit poke, input bit seq_data, input string tag);
        int n, beat, cyc, stalls;
        logic [AW-1:0] a;
        n = int'(len_m1) + 1; beat = 0; cyc = 0; stalls = 0; a = base;
        cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_base = base; cmd_len_m1 = len_m1;
        nvec++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL %s cmd_ready: got %b want 1", tag, cmd_ready); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        while (beat < n && cyc < 4 * n + 20) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = seq_data ? DW'(64'hA0 + 64'(beat)) : {$urandom, $urandom};
            if (poke && beat == n / 2) begin
                cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_base = ~base; cmd_len_m1 = '0;
            end
            @(negedge clk);
            nvec++; if ({in_ready, busy, cmd_ready, done} !== 4'b1100) begin nerr++;
                $display("FAIL %s wr_status beat %0d: got in_ready/busy/cmd_ready/done=%b want 1100", tag, beat, {in_ready, busy, cmd_ready, done}); end
            nvec++; if (mem_we !== in_valid) begin nerr++; $display("FAIL %s wr_we beat %0d: got %b want %b", tag, beat, mem_we, in_valid); end
            if (in_valid) begin
                nvec++; if (mem_addr !== a || mem_wdata !== in_data) begin nerr++;
                    $display("FAIL %s wr_beat %0d: got addr %0d data %h want addr %0d data %h", tag, beat, mem_addr, mem_wdata, a, in_data); end
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            if (in_valid) begin exp_mem[a] = in_data; a = a + 1'b1; beat++; end
            cyc++;
        end
        in_valid = 1'b0;
        nvec++; if (beat != n) begin nerr++; $display("FAIL %s wr_timeout: got %0d beats want %0d", tag, beat, n); end
        @(negedge clk);
        nvec++; if ({done, busy, cmd_ready, in_ready, mem_we} !== 5'b10100) begin nerr++;
            $display("FAIL %s wr_done: got done/busy/cmd_ready/in_ready/we=%b want 10100", tag, {done, busy, cmd_ready, in_ready, mem_we}); end
        if (!gaps) begin
            nvec++; if (cyc != n) begin nerr++; $display("FAIL %s wr_rate: got %0d cycles want %0d", tag, cyc, n); end
        end
`ifdef FMAP_BUF_STALL_CNT_EN
        nvec++; if (stall_cnt !== 16'(stalls)) begin nerr++; $display("FAIL %s wr_stall_cnt: got %0d want %0d", tag, stall_cnt, stalls); end
`else
        nvec++; if (stall_cnt !== 16'd0) begin nerr++; $display("FAIL %s wr_stall_cnt: got %0d want 0", tag, stall_cnt); end
`endif
    endtask

    // Read burst; mode 0 ready always, 1 ready pattern 1,0,0, else random.
    task automatic do_read(input logic [AW-1:0] base, input logic [AW-1:0] len_m1,
                           input int mode, input bit poke, input string tag);
        int n, got, cyc, first, stalls;
        logic [DW-1:0] expd;
        n = int'(len_m1) + 1; got = 0; cyc = 0; first = -1; stalls = 0;
        cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_base = base; cmd_len_m1 = len_m1;
        nvec++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL %s cmd_ready: got %b want 1", tag, cmd_ready); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        while (got < n && cyc < 6 * n + 20) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (poke && cyc == n / 2 + 2) begin
                cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_base = ~base; cmd_len_m1 = '0;
            end
            @(negedge clk);
            nvec++; if ({busy, cmd_ready, done, in_ready, mem_we} !== 5'b10000) begin nerr++;
                $display("FAIL %s rd_status cyc %0d: got busy/cmd_ready/done/in_ready/we=%b want 10000", tag, cyc, {busy, cmd_ready, done, in_ready, mem_we}); end
            if (out_valid === 1'b1) begin
                if (first < 0) first = cyc;
                if (out_ready) begin
                    expd = exp_mem[AW'(int'(base) + got)];
                    nvec++; if (out_data !== expd) begin nerr++;
                        $display("FAIL %s rd_word %0d: got %h want %h", tag, got, out_data, expd); end
                    got++;
                end else begin
                    stalls++;
                end
            end
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            cyc++;
        end
        out_ready = 1'b0;
        nvec++; if (got != n) begin nerr++; $display("FAIL %s rd_timeout: got %0d words want %0d", tag, got, n); end
        @(negedge clk);
        nvec++; if ({done, busy, cmd_ready, out_valid} !== 4'b1010) begin nerr++;
            $display("FAIL %s rd_done: got done/busy/cmd_ready/out_valid=%b want 1010", tag, {done, busy, cmd_ready, out_valid}); end
        nvec++; if (first != 2) begin nerr++; $display("FAIL %s rd_latency: got first valid at %0d want 2", tag, first); end
        if (mode == 0) begin
            nvec++; if (cyc != n + 2) begin nerr++; $display("FAIL %s rd_rate: got %0d cycles want %0d", tag, cyc, n + 2); end
        end
`ifdef FMAP_BUF_STALL_CNT_EN
        nvec++; if (stall_cnt !== 16'(stalls)) begin nerr++; $display("FAIL %s rd_stall_cnt: got %0d want %0d", tag, stall_cnt, stalls); end
`else
        nvec++; if (stall_cnt !== 16'd0) begin nerr++; $display("FAIL %s rd_stall_cnt: got %0d want 0", tag, stall_cnt); end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_base = '0; cmd_len_m1 = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nvec++; if ({cmd_ready, in_ready, out_valid, mem_we, busy, done} !== 6'b100000) begin nerr++;
            $display("FAIL reset_flags: got %b want 100000", {cmd_ready, in_ready, out_valid, mem_we, busy, done}); end
        nvec++; if (out_data !== '0) begin nerr++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        nvec++; if (mem_addr !== '0 || mem_wdata !== '0) begin nerr++;
            $display("FAIL reset_mem: got addr %0d wdata %h want 0 0", mem_addr, mem_wdata); end
        nvec++; if (stall_cnt !== 16'd0) begin nerr++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_basic();
        do_write(7'd0, 7'd3, 1'b0, 1'b0, 1'b1, "wr_basic");
        idle(2);
        do_read(7'd0, 7'd3, 0, 1'b0, "rd_basic");
        idle(1);
    endtask

    task automatic test_wrap();
        do_write(7'd126, 7'd3, 1'b0, 1'b0, 1'b0, "wr_wrap");
        idle(1);
        do_read(7'd126, 7'd3, 0, 1'b0, "rd_wrap");
        idle(1);
    endtask

    task automatic test_full_burst();
        do_write(7'd0, 7'd127, 1'b0, 1'b1, 1'b0, "wr_full");
        idle(1);
        do_read(7'd0, 7'd127, 0, 1'b1, "rd_full");
        idle(1);
    endtask

    task automatic test_backpressure();
        do_write(7'd40, 7'd7, 1'b1, 1'b0, 1'b0, "wr_bp");
        idle(1);
        do_read(7'd40, 7'd7, 1, 1'b0, "rd_bp_toggle");
        idle(1);
        do_read(7'd36, 7'd15, 2, 1'b0, "rd_bp_random");
        idle(1);
    endtask

    // Write then read with no idle gap between bursts.
    task automatic test_back_to_back();
        logic [AW-1:0] b, l;
        for (int i = 0; i < 6; i++) begin
            b = AW'($urandom);
            l = AW'($urandom_range(0, 20));
            do_write(b, l, 1'b1, 1'b0, 1'b0, "wr_b2b");
            do_read(b, l, 2, 1'b0, "rd_b2b");
        end
        idle(1);
    endtask

    task automatic test_reset_mid_read();
        cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_base = 7'd8; cmd_len_m1 = 7'd7;
        out_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        nvec++; if ({busy, out_valid} !== 2'b11) begin nerr++;
            $display("FAIL rst_mid_pre: got busy/out_valid=%b want 11", {busy, out_valid}); end
        rst_n = 1'b0;
        @(negedge clk);
        nvec++; if ({cmd_ready, in_ready, out_valid, mem_we, busy, done} !== 6'b100000) begin nerr++;
            $display("FAIL rst_mid_flags: got %b want 100000", {cmd_ready, in_ready, out_valid, mem_we, busy, done}); end
        nvec++; if (out_data !== '0 || mem_addr !== '0 || mem_wdata !== '0 || stall_cnt !== 16'd0) begin nerr++;
            $display("FAIL rst_mid_regs: got data %h addr %0d wdata %h stall %0d want all 0", out_data, mem_addr, mem_wdata, stall_cnt); end
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        nvec++; if ({out_valid, done, busy} !== 3'b000) begin nerr++;
            $display("FAIL rst_mid_post: got out_valid/done/busy=%b want 000", {out_valid, done, busy}); end
        do_read(7'd5, 7'd0, 0, 1'b0, "rd_after_rst");
        idle(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_full_burst();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fmap_buf_ctrl.md
Name: fmap_buf_ctrl

Overview:
- Burst controller that is the access-side counterpart of the 128x64 single-port feature-map RAM (1-cycle synchronous read, write-enable port).
- Takes a burst command (direction, base, length). Write bursts move a valid/ready input stream into the RAM; read bursts stream RAM contents out on a valid/ready interface.
- A 2-entry skid buffer absorbs the RAM read latency.
- Sits between the CNN layer engines / CPU DMA and each feature-map RAM instance.

Parameters:
- DW, 64, data width; must match RAM word width.
- AW, 7, address width; RAM depth = 2^AW = 128.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_rd  in  1  1 = read burst, 0 = write burst.
- cmd_base  in  AW  first word address.
- cmd_len_m1  in  AW  burst length minus 1 (0 → 1 word, 127 → 128 words).
- in_valid  in  1  write-stream data valid.
- in_ready  out  1  write-stream accept.
- in_data  in  DW  write-stream data.
- out_valid  out  1  read-stream data valid.
- out_ready  in  1  read-stream accept.
- out_data  out  DW  read-stream data.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid the cycle after the address is presented.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at burst completion.
- stall_cnt  out  16  backpressure cycle counter (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk edge) values: state=IDLE, cmd_ready=1, in_ready=0, out_valid=0, out_data=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, stall_cnt=0.
- Reset mid-burst aborts the burst: skid buffer emptied, in-flight read discarded, no done pulse.
- States: IDLE, WR, RD, DRAIN.
- IDLE:
  - cmd_valid&cmd_ready latches base into addr and cmd_len_m1 into remaining counter rem.
  - Goes to WR if cmd_rd=0, else RD.
- WR:
  - in_ready=1; mem_we = in_valid; mem_addr = addr; mem_wdata = in_data. Combinational pass-through, zero latency, write occurs on that edge.
  - Each accepted beat: addr increments modulo 2^AW (127 → 0 wrap), rem decrements.
  - Beat with rem==0 → IDLE, and done pulses the following cycle.
  - in_ready=0 in all other states.
- RD:
  - mem_we=0. A read is issued (mem_addr=addr) when occ + inflight − pop < 2, where occ = skid entries (0..2), inflight = read issued the previous cycle, pop = out_valid&out_ready.
  - The out_ready → issue path is combinational; this is deliberate, to sustain 1 word/cycle.
  - Each issue: addr wraps modulo 128, issue counter decrements. After the last issue → DRAIN.
- DRAIN:
  - No issues. Wait for the in-flight read to land and the skid buffer to empty.
  - The pop of the final word → IDLE, and done pulses the following cycle.
- Skid buffer:
  - FIFO order; out_data/out_valid come from the head entry (registered).
  - Returning mem_rdata is enqueued in the cycle after issue.
  - Simultaneous enqueue and pop keeps occ unchanged. occ never exceeds 2; exceeding it is an assertion failure.
- Steady-state throughput: 1 word/cycle each direction, with out_ready held high in RD.
- First out_valid appears 2 cycles after command acceptance.
- A new command is accepted no earlier than the cycle done is high (cmd_ready=1 in IDLE). Back-to-back bursts therefore have a 1-cycle gap.
- cmd_valid outside IDLE is ignored (not queued).

Optional Feature:
- Macro: FMAP_BUF_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 each cycle where (WR & !in_valid) or (out_valid & !out_ready).
  - Saturates at 0xFFFF; cleared on reset and on each command acceptance.
- Undefined: stall_cnt tied to 0; no counter logic.

Decomposition:
- Package fmap_buf_pkg: state encoding (IDLE=0, WR=1, RD=2, DRAIN=3), FMAP_DEPTH=128, FMAP_AW=7, FMAP_DW=64.
- One sub-module, fmap_skid2: 2-entry registered FIFO with push, pop, occ, and head data. Top level holds the FSM, address and length counters, and the stall counter.

Test Plan:
- Write burst: base=0, len_m1=3, in_valid continuous with data 0xA0..0xA3 → mem_we high 4 cycles at addr 0..3; done pulses 1 cycle after the 4th beat.
- Read burst: base=0, len_m1=3, out_ready=1 after the above write → out_data 0xA0..0xA3 on 4 consecutive cycles, first valid 2 cycles after cmd accept; done after the last pop.
- Wrap: write base=126, len_m1=3 → writes at addr 126,127,0,1; readback matches.
- Backpressure: read 8 words with out_ready toggling 1,0,0,1,…; occ ≤2, no data lost or duplicated, order preserved. With FMAP_BUF_STALL_CNT_EN, stall_cnt equals the count of out_ready=0 cycles while out_valid=1.
- Full burst: len_m1=127 write, then read → 128 words in order; busy high throughout; cmd_valid pulsed mid-burst is ignored.
- Reset mid-read: assert rst_n=0 during RD with occ=2 → next cycle all outputs at reset values; a following 1-word read (len_m1=0) completes normally.
